// File: rtl/dir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dir_pkg
// Brief    : Shared defaults, way-index type and tag-slice helper for the
//            cache directory tag store.
// Revision : 1.0 - initial release
// ============================================================================
package dir_pkg;

    localparam int DIR_TAG_W   = 18;
    localparam int DIR_WAYS    = 8;
    localparam int DIR_IDX_CNT = 512;

    typedef logic [$clog2(DIR_WAYS)-1:0] way_idx_t;

    function automatic logic [DIR_TAG_W-1:0] tag_slice(
        input logic [DIR_TAG_W*DIR_WAYS-1:0] row,
        input way_idx_t                      way
    );
        return row[way*DIR_TAG_W +: DIR_TAG_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dir_way_cmp.sv
`default_nettype none
// ============================================================================
// Module   : dir_way_cmp
// Brief    : Combinational per-way tag compare, hit encoder and first-invalid
//            finder for one directory set.
// Revision : 1.0 - initial release
// ============================================================================
module dir_way_cmp
    import dir_pkg::*;
#(
    parameter int TAG_W = DIR_TAG_W,
    parameter int WAYS  = DIR_WAYS,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [TAG_W*WAYS-1:0] i_row,
    input  logic [WAYS-1:0]       i_vbits,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_hit,
    output logic [WAY_W-1:0]      o_hit_way,
    output logic                  o_multi,
    output logic                  o_any_inv,
    output logic [WAY_W-1:0]      o_first_inv
);

    logic [WAYS-1:0] w_match;

    generate
        for (genvar w = 0; w < WAYS; w++) begin : g_match
            assign w_match[w] = i_vbits[w] & (i_row[w*TAG_W +: TAG_W] == i_tag);
        end
    endgenerate

    // Scanning from the top down leaves the lowest-index candidate in place.
    always_comb begin
        o_hit_way   = '0;
        o_first_inv = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) o_hit_way = WAY_W'(w);
            if (!i_vbits[w]) o_first_inv = WAY_W'(w);
        end
    end

    assign o_hit     = |w_match;
    assign o_any_inv = ~&i_vbits;
    assign o_multi   = |(w_match & (w_match - WAYS'(1)));

endmodule
`default_nettype wire

// File: rtl/dir_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : dir_tag_array
// Brief    : Set-associative directory tag/valid store with hit/way report,
//            round-robin victim choice, write-first bypass and init sweep.
// Revision : 1.0 - initial release
// ============================================================================
module dir_tag_array
    import dir_pkg::*;
#(
    parameter int TAG_W   = DIR_TAG_W,
    parameter int WAYS    = DIR_WAYS,
    parameter int IDX_CNT = DIR_IDX_CNT,
    parameter int IDX_W   = $clog2(IDX_CNT),
    parameter int WAY_W   = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IDX_W-1:0]      req_idx,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [WAY_W-1:0]      rsp_hit_way,
    output logic [TAG_W*WAYS-1:0] rsp_tags,
    output logic [WAYS-1:0]       rsp_vbits,
    output logic [WAY_W-1:0]      rsp_victim,
    input  logic                  upd_valid,
    input  logic [IDX_W-1:0]      upd_idx,
    input  logic [WAY_W-1:0]      upd_way,
    input  logic [TAG_W-1:0]      upd_tag,
    input  logic                  upd_set_v
);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic             w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) r_cnt <= r_cnt + IDX_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_cnt == IDX_W'(IDX_CNT - 1)) w_state_nxt = S_RUN;
    end

    always_comb begin
        w_run = (r_state == S_RUN);
    end

    assign init_done = w_run;
    assign req_ready = w_run;

    logic w_acc;
    logic w_upd;
    logic w_same;
    assign w_acc  = req_valid & w_run;
    assign w_upd  = upd_valid & w_run & ~rst;
    assign w_same = w_upd & (upd_idx == req_idx);

    logic [WAYS-1:0]       r_valid   [IDX_CNT];
    logic [WAY_W-1:0]      r_rr      [IDX_CNT];
    logic [TAG_W*WAYS-1:0] r_tag_mem [IDX_CNT];
    logic [TAG_W*WAYS-1:0] r_rd_row;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_valid[r_cnt] <= '0;
                r_rr[r_cnt]    <= '0;
            end else if (upd_valid) begin
                r_valid[upd_idx][upd_way] <= upd_set_v;
                if (upd_set_v) r_rr[upd_idx] <= upd_way + WAY_W'(1);
            end
        end
    end

    // Read-before-write RAM; same-set updates are merged back in stage 2.
    always_ff @(posedge clk) begin
        if (w_upd && upd_set_v) r_tag_mem[upd_idx][upd_way*TAG_W +: TAG_W] <= upd_tag;
        if (w_acc) r_rd_row <= r_tag_mem[req_idx];
    end

    logic [WAYS-1:0]  w_vb_post;
    logic [WAY_W-1:0] w_rr_post;

    always_comb begin
        w_vb_post = r_valid[req_idx];
        w_rr_post = r_rr[req_idx];
        if (w_same) begin
            w_vb_post[upd_way] = upd_set_v;
            if (upd_set_v) w_rr_post = upd_way + WAY_W'(1);
        end
    end

    logic             r_s1_valid;
    logic [TAG_W-1:0] r_s1_tag;
    logic [WAYS-1:0]  r_s1_vbits;
    logic [WAY_W-1:0] r_s1_rr;
    logic             r_s1_byp;
    logic [WAY_W-1:0] r_s1_byp_way;
    logic [TAG_W-1:0] r_s1_byp_tag;

    always_ff @(posedge clk) begin
        if (rst) r_s1_valid <= 1'b0;
        else     r_s1_valid <= w_acc;
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_s1_tag     <= req_tag;
            r_s1_vbits   <= w_vb_post;
            r_s1_rr      <= w_rr_post;
            r_s1_byp     <= w_same & upd_set_v;
            r_s1_byp_way <= upd_way;
            r_s1_byp_tag <= upd_tag;
        end
    end

    logic [TAG_W*WAYS-1:0] w_row;

    always_comb begin
        w_row = r_rd_row;
        if (r_s1_byp) w_row[r_s1_byp_way*TAG_W +: TAG_W] = r_s1_byp_tag;
    end

    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_multi;
    logic             w_any_inv;
    logic [WAY_W-1:0] w_first_inv;
    logic [WAY_W-1:0] w_victim;

    dir_way_cmp #(
        .TAG_W (TAG_W),
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_way_cmp (
        .i_row       (w_row),
        .i_vbits     (r_s1_vbits),
        .i_tag       (r_s1_tag),
        .o_hit       (w_hit),
        .o_hit_way   (w_hit_way),
        .o_multi     (w_multi),
        .o_any_inv   (w_any_inv),
        .o_first_inv (w_first_inv)
    );

    assign w_victim = w_any_inv ? w_first_inv : r_s1_rr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_hit_way <= '0;
            rsp_tags    <= '0;
            rsp_vbits   <= '0;
            rsp_victim  <= '0;
        end else begin
            rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                rsp_hit     <= w_hit;
                rsp_hit_way <= w_hit_way;
                rsp_tags    <= w_row;
                rsp_vbits   <= r_s1_vbits;
                rsp_victim  <= w_victim;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && r_s1_valid) begin
            a_single_hit: assert (!w_multi);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dir_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_dir_tag_array
// Brief    : Self-checking bench for dir_tag_array against a set-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dir_tag_array;
    import dir_pkg::*;

    localparam int TAG_W   = DIR_TAG_W;
    localparam int WAYS    = DIR_WAYS;
    localparam int IDX_CNT = DIR_IDX_CNT;
    localparam int IDX_W   = $clog2(IDX_CNT);
    localparam int WAY_W   = $clog2(WAYS);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  init_done;
    logic                  req_valid;
    logic                  req_ready;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  rsp_valid;
    logic                  rsp_hit;
    logic [WAY_W-1:0]      rsp_hit_way;
    logic [TAG_W*WAYS-1:0] rsp_tags;
    logic [WAYS-1:0]       rsp_vbits;
    logic [WAY_W-1:0]      rsp_victim;
    logic                  upd_valid;
    logic [IDX_W-1:0]      upd_idx;
    logic [WAY_W-1:0]      upd_way;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_set_v;

    always #5 clk = ~clk;

    dir_tag_array u_dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_idx     (req_idx),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_hit_way (rsp_hit_way),
        .rsp_tags    (rsp_tags),
        .rsp_vbits   (rsp_vbits),
        .rsp_victim  (rsp_victim),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_way     (upd_way),
        .upd_tag     (upd_tag),
        .upd_set_v   (upd_set_v)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-set tag/valid/pointer state.
    logic [TAG_W-1:0] m_tag [IDX_CNT][WAYS];
    bit               m_vld [IDX_CNT][WAYS];
    int               m_rr  [IDX_CNT];
    int               m_cnt;

    bit               p_v, c_v;
    int               p_hit, p_way, p_vic, c_hit, c_way, c_vic;
    logic [WAYS-1:0]  p_vb, c_vb;
    logic [TAG_W-1:0] p_tags [WAYS];
    logic [TAG_W-1:0] c_tags [WAYS];

    task automatic predict(input int idx, input logic [TAG_W-1:0] tag);
        p_hit = 0;
        p_way = 0;
        p_vic = -1;
        p_vb  = '0;
        for (int w = 0; w < WAYS; w++) begin
            p_tags[w] = m_tag[idx][w];
            p_vb[w]   = m_vld[idx][w];
            if (m_vld[idx][w] && m_tag[idx][w] == tag && p_hit == 0) begin
                p_hit = 1;
                p_way = w;
            end
            if (!m_vld[idx][w] && p_vic < 0) p_vic = w;
        end
        if (p_vic < 0) p_vic = m_rr[idx];
    endtask

    task automatic tick();
        bit rdy;
        rdy = (m_cnt >= IDX_CNT);
        @(posedge clk);
        c_v = p_v; c_hit = p_hit; c_way = p_way; c_vic = p_vic; c_vb = p_vb; c_tags = p_tags;
        if (rst) begin
            c_v   = 0;
            p_v   = 0;
            m_cnt = 0;
            for (int i = 0; i < IDX_CNT; i++) begin
                m_rr[i] = 0;
                for (int w = 0; w < WAYS; w++) m_vld[i][w] = 0;
            end
        end else if (rdy) begin
            if (upd_valid) begin
                m_vld[upd_idx][upd_way] = upd_set_v;
                if (upd_set_v) begin
                    m_tag[upd_idx][upd_way] = upd_tag;
                    m_rr[upd_idx] = (int'(upd_way) + 1) % WAYS;
                end
            end
            p_v = req_valid;
            if (req_valid) predict(int'(req_idx), req_tag);
        end else begin
            p_v = 0;
            m_cnt++;
        end
        #1;
        check("init_done", 64'(init_done), 64'(m_cnt >= IDX_CNT));
        check("rsp_valid", 64'(rsp_valid), 64'(c_v));
        if (c_v) begin
            check("rsp_hit", 64'(rsp_hit), 64'(c_hit));
            check("rsp_hit_way", 64'(rsp_hit_way), 64'(c_way));
            check("rsp_vbits", 64'(rsp_vbits), 64'(c_vb));
            check("rsp_victim", 64'(rsp_victim), 64'(c_vic));
            for (int w = 0; w < WAYS; w++)
                if (c_vb[w]) check("rsp_tag", 64'(tag_slice(rsp_tags, way_idx_t'(w))), 64'(c_tags[w]));
        end
    endtask

    task automatic drive(input bit rv, input int ridx, input int rtag,
                         input bit uv, input int uidx, input int uway, input int utag, input bit usv);
        req_valid = rv;
        req_idx   = IDX_W'(ridx);
        req_tag   = TAG_W'(rtag);
        upd_valid = uv;
        upd_idx   = IDX_W'(uidx);
        upd_way   = WAY_W'(uway);
        upd_tag   = TAG_W'(utag);
        upd_set_v = usv;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input int idx, input int way, input int tag, input bit sv);
        drive(0, 0, 0, 1, idx, way, tag, sv);
    endtask

    task automatic look_expect(input string nm, input int idx, input int tag,
                               input int hit, input int way, input int vb, input int vic);
        drive(1, idx, tag, 0, 0, 0, 0, 0);
        idle();
        check({nm, ".valid"}, 64'(rsp_valid), 64'd1);
        check({nm, ".hit"}, 64'(rsp_hit), 64'(hit));
        if (hit != 0) check({nm, ".way"}, 64'(rsp_hit_way), 64'(way));
        check({nm, ".vbits"}, 64'(rsp_vbits), 64'(vb));
        check({nm, ".victim"}, 64'(rsp_victim), 64'(vic));
    endtask

    task automatic wait_init(input bit hold_req, output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 4 * IDX_CNT) begin
            drive(hold_req, 1, 1, hold_req, 1, 0, 1, 1);
            n++;
        end
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({nm, ".rsp_hit"}, 64'(rsp_hit), 64'd0);
        check({nm, ".rsp_hit_way"}, 64'(rsp_hit_way), 64'd0);
        check({nm, ".rsp_vbits"}, 64'(rsp_vbits), 64'd0);
        check({nm, ".rsp_victim"}, 64'(rsp_victim), 64'd0);
        check({nm, ".rsp_tags_lo"}, rsp_tags[63:0], 64'd0);
        check({nm, ".init_done"}, 64'(init_done), 64'd0);
        check({nm, ".req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ridx, rtag, uidx, uway, utag;
        bit rv, uv, usv;

        m_cnt = 0;
        p_v   = 0;
        rst   = 1'b1;
        idle();
        idle();
        check_reset_state("reset");

        // Init sweep with requests and updates held high the whole time.
        rst = 1'b0;
        wait_init(1'b1, n);
        check("init_len", 64'(n), 64'(IDX_CNT));
        idle();

        upd(5, 3, 'h1ABCD, 1);
        look_expect("alloc5", 5, 'h1ABCD, 1, 3, 'h08, 0);

        for (int w = 0; w < WAYS; w++) upd(7, w, 'h100 + w, 1);
        look_expect("fill7", 7, 'h102, 1, 2, 'hFF, 0);
        upd(7, 2, 0, 0);
        look_expect("inv7", 7, 'h102, 0, 0, 'hFB, 2);

        drive(1, 9, 'h42, 1, 9, 1, 'h42, 1);
        idle();
        check("byp.hit", 64'(rsp_hit), 64'd1);
        check("byp.way", 64'(rsp_hit_way), 64'd1);
        drive(1, 9, 'h77, 1, 10, 1, 'h77, 1);
        idle();
        check("nobyp.hit", 64'(rsp_hit), 64'd0);
        check("nobyp.vbits", 64'(rsp_vbits), 64'h02);

        // Reset mid-run must wipe valid bits and pointers.
        upd(3, 0, 'h55, 1);
        upd(3, 1, 'h56, 1);
        rst = 1'b1;
        idle();
        check_reset_state("midrun");
        rst = 1'b0;
        wait_init(1'b0, n);
        check("reinit_len", 64'(n), 64'(IDX_CNT));
        look_expect("post_rst3", 3, 'h55, 0, 0, 'h00, 0);

        // Reset part-way through the sweep restarts it from the beginning.
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        wait_init(1'b1, n);
        check("restart_len", 64'(n), 64'(IDX_CNT));

        for (int i = 0; i < 3000; i++) begin
            rv   = 1'($urandom_range(0, 1));
            ridx = int'($urandom_range(0, 3));
            rtag = 'h2A5C0 + int'($urandom_range(0, 5));
            uv   = 1'($urandom_range(0, 1));
            uidx = int'($urandom_range(0, 3));
            uway = int'($urandom_range(0, WAYS - 1));
            utag = 'h2A5C0 + int'($urandom_range(0, 5));
            usv  = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < WAYS; w++)
                if (w != uway && m_vld[uidx][w] && m_tag[uidx][w] == TAG_W'(utag)) usv = 0;
            drive(rv, ridx, rtag, uv, uidx, uway, utag, usv);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
